// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - Next-PC mode encoding shared by the PC unit and its users
package pc_pkg;

  localparam int PC_MODE_W = 3;

  typedef enum logic [PC_MODE_W-1:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_J    = 3'd2,
    PC_JR   = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - Circular return-address stack with saturating count and sticky overflow/underflow flags
module pc_ras #(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [AW-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;
  logic [PW-1:0] w_top_inc;

  assign w_top_inc = r_top + 1'b1;
  assign rdata     = r_mem[r_top];
  assign empty     = (r_count == '0);
  assign full      = (r_count == DEPTH_C);
  assign ovf       = r_ovf;
  assign unf       = r_unf;

  // When full, the slot after top holds the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (push) begin
      r_top <= w_top_inc;
      if (full) r_ovf <= 1'b1;
      else      r_count <= r_count + 1'b1;
    end else if (pop) begin
      if (empty) begin
        r_unf <= 1'b1;
      end else begin
        r_top   <= r_top - 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset && push) r_mem[w_top_inc] <= wdata;
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Fetch-stage program counter with next-PC mux and return-address stack
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int            AW        = 16,
  parameter int            INC       = 4,
  parameter int            SHIFT     = 2,
  parameter int            RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 PCWre,
  input  logic [PC_MODE_W-1:0] PCSrc,
  input  logic                 br_taken,
  input  logic [AW-1:0]        imm,
  input  logic [AW-1:0]        jaddr,
  input  logic [AW-1:0]        rdata,
  output logic [AW-1:0]        PCout,
  output logic [AW-1:0]        PCnext_seq,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_ovf,
  output logic                 ras_unf,
  output logic                 misalign
);

  localparam logic [AW-1:0] INC_W = AW'(INC);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_next;
  logic [AW-1:0] w_ras_rdata;
  logic          w_push;
  logic          w_pop;

  assign PCout      = r_pc;
  assign PCnext_seq = r_pc + INC_W;

  always_comb begin
    w_target = PCnext_seq;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (PCSrc)
      PC_BR:   if (br_taken) w_target = PCnext_seq + (imm <<< SHIFT);
      PC_J:    w_target = jaddr << SHIFT;
      PC_JR:   w_target = rdata;
      PC_CALL: begin
        w_target = jaddr << SHIFT;
        w_push   = 1'b1;
      end
      // An empty pop still requests the pop so the stack can flag underflow.
      PC_RET: begin
        w_pop = 1'b1;
        if (!ras_empty) w_target = w_ras_rdata;
      end
      default: w_target = PCnext_seq;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [AW-1:0] ALIGN_MASK = AW'((1 << SHIFT) - 1);

  logic w_chk;
  logic w_mis;
  logic r_misalign;

  assign w_chk    = (PCSrc == PC_JR) || ((PCSrc == PC_RET) && !ras_empty);
  assign w_mis    = w_chk && ((w_target & ALIGN_MASK) != '0);
  assign w_next   = w_mis ? (w_target & ~ALIGN_MASK) : w_target;
  assign misalign = r_misalign;

  always_ff @(posedge clk) begin
    if (!Reset) r_misalign <= 1'b0;
    else        r_misalign <= PCWre && w_mis;
  end
`else
  assign w_next   = w_target;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!Reset)     r_pc <= RESET_VEC;
    else if (PCWre) r_pc <= w_next;
  end

  pc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .Reset (Reset),
    .push  (PCWre && w_push),
    .pop   (PCWre && w_pop),
    .wdata (PCnext_seq),
    .rdata (w_ras_rdata),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - Directed-vector bench for pc_unit with default parameters
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [2:0]  PCSrc;
  logic        br_taken;
  logic [15:0] imm;
  logic [15:0] jaddr;
  logic [15:0] rdata;
  logic [15:0] PCout;
  logic [15:0] PCnext_seq;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;
  logic        misalign;

  int n_vec = 0;
  int n_err = 0;

  pc_unit dut (
    .clk        (clk),
    .Reset      (Reset),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .br_taken   (br_taken),
    .imm        (imm),
    .jaddr      (jaddr),
    .rdata      (rdata),
    .PCout      (PCout),
    .PCnext_seq (PCnext_seq),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    PCWre = 1'b1; PCSrc = PC_JR; rdata = v;
    tick();
  endtask

  task automatic test_reset;
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0004; exp_seq[1] = 16'h0008; exp_seq[2] = 16'h000C;
    Reset = 1'b0; PCWre = 1'b1; PCSrc = PC_SEQ;
    tick();
    Reset = 1'b1;
    n_vec++; if (PCout !== 16'h0000) begin n_err++; $display("FAIL reset_pc got=%h exp=0000", PCout); end
    n_vec++; if ({ras_empty, ras_full, ras_ovf, ras_unf, misalign} !== 5'b10000) begin
      n_err++; $display("FAIL reset_flags got=%b exp=10000", {ras_empty, ras_full, ras_ovf, ras_unf, misalign}); end
    n_vec++; if (PCnext_seq !== 16'h0004) begin n_err++; $display("FAIL reset_nextseq got=%h exp=0004", PCnext_seq); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (PCout !== exp_seq[i]) begin n_err++; $display("FAIL seq%0d got=%h exp=%h", i, PCout, exp_seq[i]); end
    end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL seq_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_branch_stall;
    set_pc(16'h0010);
    PCSrc = PC_BR; imm = 16'hFFFE; br_taken = 1'b1;
    tick();
    n_vec++; if (PCout !== 16'h000C) begin n_err++; $display("FAIL br_taken got=%h exp=000C", PCout); end
    set_pc(16'h0010);
    PCSrc = PC_BR; br_taken = 1'b0;
    tick();
    n_vec++; if (PCout !== 16'h0014) begin n_err++; $display("FAIL br_not_taken got=%h exp=0014", PCout); end
    PCWre = 1'b0; PCSrc = PC_CALL; jaddr = 16'h0040;
    tick(); tick();
    n_vec++; if (PCout !== 16'h0014) begin n_err++; $display("FAIL stall_pc got=%h exp=0014", PCout); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL stall_nopush got=%b exp=1", ras_empty); end
    PCWre = 1'b1; PCSrc = PC_J; jaddr = 16'h0041;
    tick();
    n_vec++; if (PCout !== 16'h0104) begin n_err++; $display("FAIL jump got=%h exp=0104", PCout); end
  endtask

  task automatic test_call_ret;
    set_pc(16'h0020);
    PCSrc = PC_CALL; jaddr = 16'h0100;
    tick();
    n_vec++; if (PCout !== 16'h0400) begin n_err++; $display("FAIL call_pc got=%h exp=0400", PCout); end
    n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL call_empty got=%b exp=0", ras_empty); end
    PCSrc = PC_RET;
    tick();
    n_vec++; if (PCout !== 16'h0024) begin n_err++; $display("FAIL ret_pc got=%h exp=0024", PCout); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] j [5];
    logic [15:0] r [5];
    j[0] = 16'h0500; j[1] = 16'h0600; j[2] = 16'h0700; j[3] = 16'h0800; j[4] = 16'h0900;
    r[0] = 16'h2004; r[1] = 16'h1C04; r[2] = 16'h1804; r[3] = 16'h1404; r[4] = 16'h1408;
    set_pc(16'h1000);
    for (int i = 0; i < 5; i++) begin
      PCSrc = PC_CALL; jaddr = j[i];
      tick();
      n_vec++; if (PCout !== (j[i] << 2)) begin n_err++; $display("FAIL call%0d got=%h exp=%h", i, PCout, j[i] << 2); end
      if (i == 3) begin
        n_vec++; if ({ras_full, ras_ovf} !== 2'b10) begin n_err++; $display("FAIL full4 got=%b exp=10", {ras_full, ras_ovf}); end
      end
    end
    n_vec++; if ({ras_full, ras_ovf} !== 2'b11) begin n_err++; $display("FAIL ovf got=%b exp=11", {ras_full, ras_ovf}); end
    for (int i = 0; i < 5; i++) begin
      PCSrc = PC_RET;
      tick();
      n_vec++; if (PCout !== r[i]) begin n_err++; $display("FAIL ret%0d got=%h exp=%h", i, PCout, r[i]); end
    end
    PCSrc = PC_SEQ;
    tick();
    n_vec++; if ({ras_empty, ras_ovf, ras_unf} !== 3'b111) begin
      n_err++; $display("FAIL sticky got=%b exp=111", {ras_empty, ras_ovf, ras_unf}); end
  endtask

  task automatic test_wrap_reset;
    set_pc(16'hFFFC);
    n_vec++; if (PCnext_seq !== 16'h0000) begin n_err++; $display("FAIL wrap_nextseq got=%h exp=0000", PCnext_seq); end
    PCSrc = PC_SEQ;
    tick();
    n_vec++; if (PCout !== 16'h0000) begin n_err++; $display("FAIL wrap got=%h exp=0000", PCout); end
    PCSrc = PC_CALL; jaddr = 16'h0200;
    tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1; PCSrc = PC_SEQ;
    n_vec++; if (PCout !== 16'h0000) begin n_err++; $display("FAIL rst_mid_pc got=%h exp=0000", PCout); end
    n_vec++; if ({ras_empty, ras_ovf, ras_unf} !== 3'b100) begin
      n_err++; $display("FAIL rst_mid_flags got=%b exp=100", {ras_empty, ras_ovf, ras_unf}); end
  endtask

  task automatic test_align;
    set_pc(16'h0123);
`ifdef PC_ALIGN_CHECK_EN
    n_vec++; if (PCout !== 16'h0120) begin n_err++; $display("FAIL jr_align got=%h exp=0120", PCout); end
    n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL misalign_set got=%b exp=1", misalign); end
`else
    n_vec++; if (PCout !== 16'h0123) begin n_err++; $display("FAIL jr_raw got=%h exp=0123", PCout); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL misalign_tied got=%b exp=0", misalign); end
`endif
    PCSrc = PC_SEQ;
    tick();
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL misalign_clear got=%b exp=0", misalign); end
  endtask

  initial begin
    Reset = 1'b0; PCWre = 1'b0; PCSrc = PC_SEQ; br_taken = 1'b0;
    imm = '0; jaddr = '0; rdata = '0;
    test_reset();
    test_branch_stall();
    test_call_ret();
    test_back_to_back();
    test_wrap_reset();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the CPU fetch stage. Holds the PC and computes the next PC internally.
- Next-PC modes: sequential, conditional branch, absolute jump, register jump, call and return.
- Contains a small circular return-address stack (RAS) for call/return.
- Replaces the fixed 16-bit hold/load PC register; the fetch stage consumes PCout and PCnext_seq.

Parameters:
- AW, 16: PC/address width in bits.
- INC, 4: sequential increment in bytes.
- SHIFT, 2: left shift applied to branch offsets and jump targets (word to byte).
- RAS_DEPTH, 4: return-address stack entries, power of two, ≥2.
- RESET_VEC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- Reset  in  1  synchronous reset, active-low
- PCWre  in  1  PC write enable; 0 = stall
- PCSrc  in  3  next-PC mode, encoding per pc_pkg
- br_taken  in  1  branch condition, used only in BRANCH mode
- imm  in  AW  sign-extended branch offset in words
- jaddr  in  AW  absolute jump target in words
- rdata  in  AW  register-jump target in bytes
- PCout  out  AW  current PC
- PCnext_seq  out  AW  PCout+INC, combinational; the link value
- ras_empty  out  1  RAS holds 0 valid entries
- ras_full  out  1  RAS holds RAS_DEPTH valid entries
- ras_ovf  out  1  sticky: a push occurred while full
- ras_unf  out  1  sticky: a pop occurred while empty
- misalign  out  1  single-cycle pulse; see Optional Feature

Behaviour:
Clocking and stall:
- All state updates on posedge clk only. Reset is synchronous, active-low: Reset==0 at an edge overrides everything.
- Reset values: PCout=RESET_VEC, RAS count=0, RAS pointer=0, ras_ovf=0, ras_unf=0, misalign=0. ras_empty=1 and ras_full=0 follow from count=0.
- PCWre==0: PC, RAS, flags all hold; no push or pop occurs; misalign=0.

Next PC when PCWre==1 (all arithmetic modulo 2^AW, wrap silently):
- SEQ(0): PCout+INC.
- BRANCH(1): if br_taken then PCout+INC+(imm<<<SHIFT), else PCout+INC.
- JUMP(2): jaddr<<SHIFT.
- JR(3): rdata.
- CALL(4): jaddr<<SHIFT; push PCout+INC onto the RAS.
- RET(5): pop the RAS; next PC = popped value.
- Codes 6 and 7: treated as SEQ.

RAS:
- Circular buffer with a top pointer and a saturating count 0..RAS_DEPTH.
- Push while full: overwrite the oldest entry, count stays RAS_DEPTH, set ras_ovf.
- Pop while empty: next PC = PCout+INC, count stays 0, set ras_unf.
- ras_ovf and ras_unf stay set until reset.
- Only one push or pop can occur per cycle; CALL and RET are mutually exclusive by encoding.
- Reset mid-sequence discards all RAS contents.

Latency:
- New PCout is visible in the cycle after the edge. PCnext_seq has zero latency.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: for JR targets and RET-popped targets whose low SHIFT bits are nonzero:
  - those bits are cleared before loading the PC;
  - misalign pulses 1 for the cycle after that edge.
- Undefined: targets are loaded unmodified and misalign is tied to 0.
- The port exists in both builds.

Decomposition:
- pc_pkg holds the PCSrc enum localparams (PC_SEQ, PC_BR, PC_J, PC_JR, PC_CALL, PC_RET) and the 3-bit mode width constant.
- Sub-module pc_ras (parameters AW, RAS_DEPTH) owns storage, pointer, count, full/empty and sticky flags. It takes push/pop/wdata and returns rdata.
- The pc_unit top owns the PC register and next-PC mux.

Test Plan:
1. Reset=0 for 1 edge, then SEQ for 3 edges -> PCout 0x0000, 0x0004, 0x0008, 0x000C; ras_empty=1.
2. PC=0x0010, BRANCH, imm=-2, br_taken=1 -> PCout=0x000C. Repeat with br_taken=0 -> 0x0014. Then PCWre=0 for 2 edges -> PC holds.
3. PC=0x0020, CALL jaddr=0x0100 -> PCout=0x0400, RAS top=0x0024. Then RET -> PCout=0x0024, ras_empty=1.
4. RAS_DEPTH=4: five CALLs from PCs A..E, then five RETs:
   - CALLs -> ras_full=1, ras_ovf=1;
   - first four RETs return E+4, D+4, C+4, B+4;
   - fifth RET -> PC+4 and ras_unf=1;
   - both flags stay 1 until reset.
5. PC=0xFFFC, SEQ -> PCout=0x0000 (wrap). Then CALL during Reset=0 -> PCout=RESET_VEC, ras_empty=1.
6. With PC_ALIGN_CHECK_EN: JR rdata=0x0123 -> PCout=0x0120, misalign=1 for one cycle. Without the macro -> PCout=0x0123, misalign=0.
